// File: rtl/echo_sensor_sched.sv
// Round-robin scheduler sharing one echo pulse-width measurement path between two sensors.
// Optional macro ECHO_TIMEOUT_HOLD_EN: a timeout keeps the old width and suppresses valid.
module echo_sensor_sched #(
  parameter int PRESCALE      = 100,
  parameter int TRIG_TICKS    = 1,
  parameter int TIMEOUT       = 6000,
  parameter int GAP_TICKS     = 600,
  parameter int DEFAULT_WIDTH = 300
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        enable,
  input  logic        echo0,
  input  logic        echo1,
  output logic        trig0,
  output logic        trig1,
  output logic [12:0] width0,
  output logic [12:0] width1,
  output logic        valid0,
  output logic        valid1,
  output logic [1:0]  timeout_flag,
  output logic        active_ch
);

  localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;

  localparam logic [2:0] ST_IDLE    = 3'd0;
  localparam logic [2:0] ST_TRIG    = 3'd1;
  localparam logic [2:0] ST_WAIT    = 3'd2;
  localparam logic [2:0] ST_MEASURE = 3'd3;
  localparam logic [2:0] ST_GAP     = 3'd4;

  localparam logic [PW-1:0] PRESC_LAST = PW'(PRESCALE - 1);
  localparam logic [12:0]   DEF_W      = 13'(DEFAULT_WIDTH);
  localparam logic [12:0]   TMO_W      = 13'(TIMEOUT);
  localparam logic [15:0]   TRIG_LAST  = 16'(TRIG_TICKS - 1);
  localparam logic [15:0]   WAIT_LAST  = 16'(TIMEOUT - 1);
  localparam logic [15:0]   GAP_LAST   = 16'(GAP_TICKS - 1);

  logic [PW-1:0]    presc_r;
  logic             tick_s;
  logic [2:0]       state_r;
  logic [15:0]      tcnt_r;
  logic [12:0]      wacc_r;
  logic             ch_r;
  logic [1:0]       trig_r;
  logic [1:0]       valid_r;
  logic [1:0]       tflag_r;
  logic [1:0][12:0] width_r;
  logic             echo_s;
  logic             meas_done_s;
  logic             timeout_s;

  assign tick_s = (presc_r == PRESC_LAST);
  assign echo_s = ch_r ? echo1 : echo0;

  // Decode the measurement outcome decided on the current tick.
  always_comb begin
    meas_done_s = 1'b0;
    timeout_s   = 1'b0;
    if (tick_s && (state_r == ST_MEASURE)) begin
      meas_done_s = ~echo_s;
      timeout_s   = echo_s && (wacc_r == TMO_W);
    end else if (tick_s && (state_r == ST_WAIT)) begin
      timeout_s   = ~echo_s && (tcnt_r == WAIT_LAST);
    end else begin
      meas_done_s = 1'b0;
      timeout_s   = 1'b0;
    end
  end

  // Free-running tick prescaler.
  always_ff @(posedge clk) begin
    if (reset) begin
      presc_r <= '0;
    end else if (tick_s) begin
      presc_r <= '0;
    end else begin
      presc_r <= presc_r + PW'(1);
    end
  end

  // Scheduler FSM: trigger, wait for echo, measure, gap, then hand over to the other channel.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r <= ST_IDLE;
      tcnt_r  <= 16'd0;
      wacc_r  <= 13'd0;
      ch_r    <= 1'b0;
      trig_r  <= 2'b00;
    end else if (tick_s) begin
      case (state_r)
        ST_IDLE: begin
          if (enable) begin
            state_r      <= ST_TRIG;
            tcnt_r       <= 16'd0;
            trig_r[ch_r] <= 1'b1;
          end else begin
            state_r <= ST_IDLE;
          end
        end
        ST_TRIG: begin
          if (tcnt_r == TRIG_LAST) begin
            trig_r  <= 2'b00;
            tcnt_r  <= 16'd0;
            state_r <= ST_WAIT;
          end else begin
            tcnt_r <= tcnt_r + 16'd1;
          end
        end
        ST_WAIT: begin
          // An echo already high counts from this first sample; no edge needed.
          if (echo_s) begin
            wacc_r  <= 13'd1;
            state_r <= ST_MEASURE;
          end else if (tcnt_r == WAIT_LAST) begin
            tcnt_r  <= 16'd0;
            state_r <= ST_GAP;
          end else begin
            tcnt_r <= tcnt_r + 16'd1;
          end
        end
        ST_MEASURE: begin
          if (echo_s && (wacc_r != TMO_W)) begin
            wacc_r <= wacc_r + 13'd1;
          end else begin
            tcnt_r  <= 16'd0;
            state_r <= ST_GAP;
          end
        end
        ST_GAP: begin
          if (tcnt_r == GAP_LAST) begin
            tcnt_r  <= 16'd0;
            ch_r    <= ~ch_r;
            state_r <= ST_IDLE;
          end else begin
            tcnt_r <= tcnt_r + 16'd1;
          end
        end
        default: begin
          state_r <= ST_IDLE;
          tcnt_r  <= 16'd0;
          trig_r  <= 2'b00;
        end
      endcase
    end else begin
      state_r <= state_r;
    end
  end

  // Result registers; only the active channel's slot is ever written.
  always_ff @(posedge clk) begin
    if (reset) begin
      width_r <= {DEF_W, DEF_W};
      valid_r <= 2'b00;
      tflag_r <= 2'b00;
    end else begin
      valid_r <= 2'b00;
      if (meas_done_s) begin
        width_r[ch_r] <= wacc_r;
        valid_r[ch_r] <= 1'b1;
        tflag_r[ch_r] <= 1'b0;
      end else if (timeout_s) begin
`ifdef ECHO_TIMEOUT_HOLD_EN
        tflag_r[ch_r] <= 1'b1;
`else
        width_r[ch_r] <= DEF_W;
        valid_r[ch_r] <= 1'b1;
        tflag_r[ch_r] <= 1'b1;
`endif
      end else begin
        tflag_r <= tflag_r;
      end
    end
  end

  assign trig0        = trig_r[0];
  assign trig1        = trig_r[1];
  assign width0       = width_r[0];
  assign width1       = width_r[1];
  assign valid0       = valid_r[0];
  assign valid1       = valid_r[1];
  assign timeout_flag = tflag_r;
  assign active_ch    = ch_r;

endmodule

// File: tb/tb_echo_sensor_sched.sv
// Randomised bench for echo_sensor_sched against a tick-timeline reference model.
module tb_echo_sensor_sched;

  localparam int P    = 4;
  localparam int T    = 2;
  localparam int TO   = 20;
  localparam int G    = 3;
  localparam int DW   = 300;
  localparam int MAXC = 40000;
  localparam int NPLAN = 50;

  logic        clk = 1'b0;
  logic        reset, enable, echo0, echo1;
  logic        trig0, trig1, valid0, valid1, active_ch;
  logic [12:0] width0, width1;
  logic [1:0]  timeout_flag;

  echo_sensor_sched #(
    .PRESCALE(P), .TRIG_TICKS(T), .TIMEOUT(TO), .GAP_TICKS(G), .DEFAULT_WIDTH(DW)
  ) dut (
    .clk(clk), .reset(reset), .enable(enable), .echo0(echo0), .echo1(echo1),
    .trig0(trig0), .trig1(trig1), .width0(width0), .width1(width1),
    .valid0(valid0), .valid1(valid1), .timeout_flag(timeout_flag), .active_ch(active_ch)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string tag, input int obs, input int exp_v);
    n_tests++;
    if (obs != exp_v) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp_v);
    end
  endtask

  // Reference model: one measurement described by a plan in tick units.
  bit m_idle, ch_m, p_never, p_tmo;
  int k0, dtick, gap_end, pd, ph, jend, rst_j, plan_cnt, n_last;
  int w_exp[2];
  int f_exp, v_exp;

  task automatic model_reset();
    m_idle   = 1'b1;
    ch_m     = 1'b0;
    w_exp[0] = DW;
    w_exp[1] = DW;
    f_exp    = 0;
    v_exp    = 0;
    rst_j    = -1;
    n_last   = 0;
  endtask

  task automatic start_plan(input int k);
    int r;
    k0 = k;
    plan_cnt++;
    p_never = 1'b0;
    pd = 0;
    ph = 1;
    r = int'($urandom_range(0, 9));
    if (plan_cnt == 1) r = 10;
    if (plan_cnt == 2) r = 5;
    case (r)
      5:  p_never = 1'b1;
      6:  begin pd = int'($urandom_range(0, 3)); ph = TO + 1 + int'($urandom_range(0, 5)); end
      7:  begin pd = int'($urandom_range(0, 3)); ph = TO; end
      8:  begin pd = TO - 1; ph = int'($urandom_range(1, 4)); end
      9:  begin pd = 0; ph = 1; end
      10: begin pd = 2; ph = 5; end
      default: begin pd = int'($urandom_range(0, 6)); ph = int'($urandom_range(1, TO)); end
    endcase
    if (p_never) begin
      jend = TO - 1; p_tmo = 1'b1;
    end else if (ph > TO) begin
      jend = pd + TO; p_tmo = 1'b1;
    end else begin
      jend = pd + ph; p_tmo = 1'b0;
    end
    dtick   = k0 + T + 1 + jend;
    gap_end = dtick + G;
    rst_j   = -1;
    if (plan_cnt > 4 && $urandom_range(0, 7) == 0) rst_j = int'($urandom_range(0, jend));
  endtask

  task automatic decide();
    if (p_tmo) begin
      f_exp = f_exp | (1 << ch_m);
`ifndef ECHO_TIMEOUT_HOLD_EN
      w_exp[ch_m] = DW;
      v_exp = 1 << ch_m;
`endif
    end else begin
      f_exp = f_exp & ~(1 << ch_m);
      w_exp[ch_m] = ph;
      v_exp = 1 << ch_m;
    end
  endtask

  task automatic process_tick(input int k);
    if (m_idle) begin
      if (enable) begin
        m_idle = 1'b0;
        start_plan(k);
      end
    end else begin
      if (k == dtick) decide();
      if (k == gap_end) begin
        ch_m   = ~ch_m;
        m_idle = 1'b1;
      end
    end
  endtask

  initial begin
    int texp, nn, j, cyc;
    bit pe;
    reset = 1'b1;
    enable = 1'b0;
    echo0 = 1'b0;
    echo1 = 1'b0;
    plan_cnt = 0;
    model_reset();
    cyc = 0;
    while (cyc < MAXC && !(plan_cnt >= NPLAN && m_idle)) begin
      @(negedge clk);
      if (reset) begin
        model_reset();
      end else begin
        n_last++;
        v_exp = 0;
        if (n_last % P == 0) process_tick(n_last / P);
      end
      texp = 0;
      if (!m_idle && n_last >= k0 * P && n_last < (k0 + T) * P) texp = 1 << ch_m;
      chk("trig", int'({trig1, trig0}), texp);
      chk("valid", int'({valid1, valid0}), v_exp);
      chk("width0", int'(width0), w_exp[0]);
      chk("width1", int'(width1), w_exp[1]);
      chk("timeout_flag", int'(timeout_flag), f_exp);
      chk("active_ch", int'(active_ch), int'(ch_m));

      // Stimulus for the next rising edge; idle or inactive echoes are random noise.
      reset = (cyc < 3) ? 1'b1 : 1'b0;
      if (cyc == 3) enable = 1'b1;
      if (cyc > 3 && cyc % 50 == 0) enable = ($urandom_range(0, 4) != 0);
      echo0 = 1'($urandom_range(0, 1));
      echo1 = 1'($urandom_range(0, 1));
      nn = n_last + 1;
      if (!m_idle && nn % P == 0) begin
        j = nn / P - (k0 + T + 1);
        if (j >= 0 && j <= jend) begin
          pe = !p_never && j >= pd && j < pd + ph;
          if (ch_m) echo1 = pe;
          else      echo0 = pe;
          if (j == rst_j) reset = 1'b1;
        end
      end
      cyc++;
    end
    chk("plans_done", int'(plan_cnt >= NPLAN), 1);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/echo_sensor_sched.md
Name: echo_sensor_sched

Overview:
- Scheduler that shares one pulse-width measurement datapath between two echo-ranging sensors: channel 0 is the pitch antenna, channel 1 is the volume antenna.
- Fires a trigger pulse on the active channel, then measures that channel's echo width in prescaled ticks.
- Latches a per-channel 13-bit result and alternates channels round-robin.
- Sits between the sensor pins and the tone/volume generators; replaces two free-running width detectors.

Parameters:
- PRESCALE, 100: clk cycles per tick; all FSM timing is in ticks.
- TRIG_TICKS, 1: trigger pulse length in ticks (>=1).
- TIMEOUT, 6000: max ticks waiting for an echo, and max echo width (<=8191).
- GAP_TICKS, 600: idle ticks after each measurement before switching channel.
- DEFAULT_WIDTH, 300: width value loaded at reset and on timeout.

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- enable  in  1  permits new measurement cycles; sampled only in IDLE
- echo0  in  1  channel 0 echo, pre-synchronised
- echo1  in  1  channel 1 echo, pre-synchronised
- trig0  out  1  channel 0 trigger
- trig1  out  1  channel 1 trigger
- width0  out  13  last channel 0 width, in ticks
- width1  out  13  last channel 1 width, in ticks
- valid0  out  1  one-cycle strobe when width0 updates
- valid1  out  1  one-cycle strobe when width1 updates
- timeout_flag  out  2  bit n sticky: channel n's last cycle timed out
- active_ch  out  1  channel currently owned by the scheduler

Behaviour:
- All outputs are registered.
- Reset values:
  - presc=0, state=IDLE, active_ch=0.
  - trig0/trig1=0, valid0/valid1=0, timeout_flag=0.
  - width0=width1=DEFAULT_WIDTH.
  - internal tick count tcnt=0 and width accumulator wacc=0.
- Reset mid-operation aborts immediately with no output update.
- Prescaler: presc counts 0..PRESCALE-1 and wraps. tick=1 in cycles where presc==PRESCALE-1. The FSM changes state only on tick cycles.
- States: IDLE, TRIG, WAIT_ECHO, MEASURE, GAP.
- IDLE:
  - On tick with enable=1: go to TRIG, tcnt=0, trig[active_ch]<=1.
  - With enable=0: stay in IDLE.
- TRIG: on tick, tcnt++. When tcnt==TRIG_TICKS-1: trig<=0, tcnt=0, go to WAIT_ECHO.
- WAIT_ECHO: on tick, sample echo[active_ch].
  - 1: wacc=1, go to MEASURE.
  - 0 and tcnt==TIMEOUT-1: timeout event, go to GAP.
  - Otherwise tcnt++.
- MEASURE: on tick, sample echo[active_ch].
  - 1 and wacc==TIMEOUT: timeout event, go to GAP.
  - 1 otherwise: wacc++.
  - 0: width[active_ch]<=wacc, valid[active_ch]<=1 for one cycle, timeout_flag[active_ch]<=0, go to GAP.
- Timeout event (default build): width[active_ch]<=DEFAULT_WIDTH, valid[active_ch] pulses, timeout_flag[active_ch]<=1.
- GAP: tcnt counts GAP_TICKS ticks. On the last one: active_ch toggles, go to IDLE.
- Output timing:
  - valid and width update in the clk cycle after the deciding tick, together.
  - trig rises the cycle after the IDLE->TRIG tick.
  - trig is high for exactly TRIG_TICKS*PRESCALE cycles.
- Exclusivity:
  - Only one trig output is ever high.
  - The inactive channel's echo is ignored entirely.
  - The inactive channel's width, valid and flag outputs are never disturbed.
- Echo already high when WAIT_ECHO is entered: measured from the first sampled tick; no edge is required.
- Deasserting enable mid-cycle: the current measurement and GAP complete, then the scheduler parks in IDLE with the toggled active_ch.
- Width arithmetic: 13-bit unsigned. wacc never exceeds TIMEOUT, so it never wraps.

Optional Feature:
- Macro: ECHO_TIMEOUT_HOLD_EN.
- Defined:
  - A timeout leaves width[active_ch] unchanged.
  - valid does not pulse.
  - timeout_flag[active_ch] is still set.
- Undefined: timeout behaviour exactly as described under Behaviour.

Test Plan (bench parameters PRESCALE=4, TRIG_TICKS=2, TIMEOUT=20, GAP_TICKS=3, DEFAULT_WIDTH=300):
1. Reset, then release with enable=1 -> width0=width1=300 and flags 0; trig0 is high for exactly 8 cycles; trig1 stays 0.
2. echo0 high for exactly 5 sampled ticks after trig0 falls -> width0=5, single valid0 pulse, width1 unchanged, then active_ch=1 and trig1 fires.
3. echo1 never rises -> after 20 ticks width1=300, valid1 pulses, timeout_flag=2'b10; the next good channel 1 measurement clears bit 1.
4. echo0 stuck high -> timeout at wacc=20: width0=300, timeout_flag[0]=1. With ECHO_TIMEOUT_HOLD_EN: width0 keeps its prior value and there is no valid0 pulse.
5. enable dropped during MEASURE -> measurement completes normally, GAP runs, FSM parks in IDLE with no further trig. Re-asserting enable resumes on the toggled channel.
6. reset asserted mid-MEASURE -> next cycle all outputs are at reset values and no valid pulse occurs.
